// File: rtl/student_iis_receiver.sv
// I2S serial-to-parallel receiver: assembles a left and a right word per LRCLK frame and
// presents the stereo pair with a one-cycle valid strobe. Optional frame_err_O via STUDENT_IIS_RX_FRAME_ERR_EN.
module student_iis_receiver #(
    parameter int DATA_SIZE_FIR_IN = 24
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        AC_ADC_SDATA,
    input  logic                        LRCLK_Rise,
    input  logic                        LRCLK_Fall,
    input  logic                        BCLK_Rise,
    output logic [DATA_SIZE_FIR_IN-1:0] Data_L_O,
    output logic [DATA_SIZE_FIR_IN-1:0] Data_R_O,
    output logic                        valid_strobe_O
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
    ,
    output logic                        frame_err_O
`endif
);

    localparam int CNT_W = $clog2(DATA_SIZE_FIR_IN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_SIZE_FIR_IN);
    localparam logic CH_L = 1'b0;
    localparam logic CH_R = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SKIP  = 2'd1,
        S_SHIFT = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                      state_r, state_s;
    logic [CNT_W-1:0]            cnt_r, cnt_s, cnt_inc_s;
    logic [DATA_SIZE_FIR_IN-1:0] sr_r, sr_s, shift_s;
    logic                        chan_r, chan_s;
    logic [DATA_SIZE_FIR_IN-1:0] left_hold_r, left_hold_s;
    logic                        left_ok_r, left_ok_s;
    logic [DATA_SIZE_FIR_IN-1:0] data_l_r, data_l_s;
    logic [DATA_SIZE_FIR_IN-1:0] data_r_r, data_r_s;
    logic                        valid_r, valid_s;
    logic                        lr_any_s;
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
    logic                        frame_err_r, frame_err_s;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and datapath decode; an LRCLK strobe overrides any BCLK strobe in the same cycle
    always_comb begin
        lr_any_s    = LRCLK_Fall | LRCLK_Rise;
        shift_s     = {sr_r[DATA_SIZE_FIR_IN-2:0], AC_ADC_SDATA};
        cnt_inc_s   = cnt_r + CNT_W'(1);
        state_s     = state_r;
        cnt_s       = cnt_r;
        sr_s        = sr_r;
        chan_s      = chan_r;
        left_hold_s = left_hold_r;
        left_ok_s   = left_ok_r;
        data_l_s    = data_l_r;
        data_r_s    = data_r_r;
        valid_s     = 1'b0;
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
        frame_err_s = 1'b0;
`endif
        if (lr_any_s) begin
            state_s = S_SKIP;
            cnt_s   = '0;
            sr_s    = '0;
            chan_s  = LRCLK_Fall ? CH_L : CH_R;
            // Abort of a partial word: an aborted right word invalidates the pending left
            if ((state_r == S_SKIP) || (state_r == S_SHIFT)) begin
                if (chan_r == CH_R) begin
                    left_ok_s = 1'b0;
                end else begin
                    left_ok_s = left_ok_r;
                end
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
                frame_err_s = 1'b1;
`endif
            end else begin
                left_ok_s = left_ok_r;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_s = S_IDLE;
                end
                S_SKIP: begin
                    if (BCLK_Rise) begin
                        state_s = S_SHIFT;
                    end else begin
                        state_s = S_SKIP;
                    end
                end
                S_SHIFT: begin
                    if (BCLK_Rise) begin
                        sr_s  = shift_s;
                        cnt_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_LAST) begin
                            state_s = S_WAIT;
                            if (chan_r == CH_L) begin
                                left_hold_s = shift_s;
                                left_ok_s   = 1'b1;
                            end else if (left_ok_r) begin
                                data_l_s  = left_hold_r;
                                data_r_s  = shift_s;
                                valid_s   = 1'b1;
                                left_ok_s = 1'b0;
                            end else begin
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
                                frame_err_s = 1'b1;
`endif
                                left_ok_s = 1'b0;
                            end
                        end else begin
                            state_s = S_SHIFT;
                        end
                    end else begin
                        state_s = S_SHIFT;
                    end
                end
                S_WAIT: begin
                    state_s = S_WAIT;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_r       <= '0;
            sr_r        <= '0;
            chan_r      <= CH_L;
            left_hold_r <= '0;
            left_ok_r   <= 1'b0;
            data_l_r    <= '0;
            data_r_r    <= '0;
            valid_r     <= 1'b0;
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
            frame_err_r <= 1'b0;
`endif
        end else begin
            cnt_r       <= cnt_s;
            sr_r        <= sr_s;
            chan_r      <= chan_s;
            left_hold_r <= left_hold_s;
            left_ok_r   <= left_ok_s;
            data_l_r    <= data_l_s;
            data_r_r    <= data_r_s;
            valid_r     <= valid_s;
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
            frame_err_r <= frame_err_s;
`endif
        end
    end

    assign Data_L_O       = data_l_r;
    assign Data_R_O       = data_r_r;
    assign valid_strobe_O = valid_r;
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
    assign frame_err_O    = frame_err_r;
`endif

endmodule

// File: tb/tb_student_iis_receiver.sv
// Scoreboard bench for student_iis_receiver: directed I2S frames, expected pairs queued by the
// stimulus and checked by an independent monitor on valid_strobe_O.
module tb_student_iis_receiver;

    localparam int W    = 24;
    localparam int SLOT = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          AC_ADC_SDATA = 1'b0;
    logic          LRCLK_Rise = 1'b0;
    logic          LRCLK_Fall = 1'b0;
    logic          BCLK_Rise = 1'b0;
    logic [W-1:0]  Data_L_O;
    logic [W-1:0]  Data_R_O;
    logic          valid_strobe_O;
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
    logic          frame_err_O;
    int            fe_cnt = 0;
`endif

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
        logic [31:0]  cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_strobe = 0;
    logic [31:0]   cyc = 32'd0;

    student_iis_receiver #(.DATA_SIZE_FIR_IN(W)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .AC_ADC_SDATA   (AC_ADC_SDATA),
        .LRCLK_Rise     (LRCLK_Rise),
        .LRCLK_Fall     (LRCLK_Fall),
        .BCLK_Rise      (BCLK_Rise),
        .Data_L_O       (Data_L_O),
        .Data_R_O       (Data_R_O),
        .valid_strobe_O (valid_strobe_O)
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
        ,
        .frame_err_O    (frame_err_O)
`endif
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 32'd1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard, including its cycle
    always @(negedge clk_i) begin
        if (rst_ni && valid_strobe_O === 1'b1) begin
            n_strobe++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none (L=%h R=%h)",
                         cyc, Data_L_O, Data_R_O);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data_l", Data_L_O, e.l);
                check("data_r", Data_R_O, e.r);
                n_cmp++;
                if (cyc !== e.cyc) begin
                    n_err++;
                    $display("FAIL strobe_cycle: got %0d, expected %0d", cyc, e.cyc);
                end
            end
        end
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
        if (rst_ni && frame_err_O === 1'b1) fe_cnt++;
`endif
    end

    // One channel slot: LRCLK strobe, then delay slot, nbits data bits MSB first, then padding
    task automatic send_slot(input bit is_left, input logic [W-1:0] word, input int nbits,
                             input bit dly, input bit pad, input bit collide,
                             input bit exp_strobe, input logic [W-1:0] exp_l);
        int total;
        logic b;
        total = (nbits == W) ? SLOT : nbits + 1;
        @(negedge clk_i);
        LRCLK_Fall   = is_left;
        LRCLK_Rise   = ~is_left;
        BCLK_Rise    = collide;
        AC_ADC_SDATA = collide;
        @(negedge clk_i);
        LRCLK_Fall = 1'b0;
        LRCLK_Rise = 1'b0;
        BCLK_Rise  = 1'b0;
        for (int k = 0; k < total; k++) begin
            repeat (3) @(negedge clk_i);
            if (k == 0) b = dly;
            else if (k <= W) b = word[W-k];
            else b = pad;
            AC_ADC_SDATA = b;
            BCLK_Rise    = 1'b1;
            if (k == W && exp_strobe) exp_q.push_back('{l: exp_l, r: word, cyc: cyc + 32'd1});
            @(negedge clk_i);
            BCLK_Rise    = 1'b0;
            AC_ADC_SDATA = 1'b0;
        end
    endtask

    task automatic frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit dly, input bit pad);
        send_slot(1'b1, l, W, dly, pad, 1'b0, 1'b0, '0);
        send_slot(1'b0, r, W, dly, pad, 1'b0, 1'b1, l);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        check("reset_data_l", Data_L_O, 24'h000000);
        check("reset_data_r", Data_R_O, 24'h000000);
        check("reset_valid", {23'd0, valid_strobe_O}, 24'h000000);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        frame(24'hA5A5A5, 24'h5A5A5A, 1'b0, 1'b0);
        frame(24'h000000, 24'h000001, 1'b1, 1'b0);
        frame(24'h123456, 24'h654321, 1'b0, 1'b1);

        // Short left word aborted by LRCLK_Rise, then an orphan right word
        send_slot(1'b1, 24'hFFFFFF, 10, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        send_slot(1'b0, 24'h0F0F0F, W, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        repeat (4) @(negedge clk_i);
        check("short_hold_l", Data_L_O, 24'h123456);
        check("short_hold_r", Data_R_O, 24'h654321);

        // Collision: BCLK in the LRCLK_Fall cycle must not be the delay slot
        send_slot(1'b1, 24'h3C3C3C, W, 1'b1, 1'b0, 1'b1, 1'b0, '0);
        send_slot(1'b0, 24'h00C3C3, W, 1'b1, 1'b0, 1'b0, 1'b1, 24'h3C3C3C);

        // Reset during bit 12 of the right word
        send_slot(1'b1, 24'h111111, W, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        send_slot(1'b0, 24'h222222, 12, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("midrst_data_l", Data_L_O, 24'h000000);
        check("midrst_data_r", Data_R_O, 24'h000000);
        check("midrst_valid", {23'd0, valid_strobe_O}, 24'h000000);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        frame(24'h0ABCDE, 24'h765432, 1'b0, 1'b1);

        repeat (20) @(negedge clk_i);
        check("queue_empty", 24'(exp_q.size()), 24'd0);
        check("strobe_count", 24'(n_strobe), 24'd5);
`ifdef STUDENT_IIS_RX_FRAME_ERR_EN
        check("frame_err_count", 24'(fe_cnt), 24'd2);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
